johnson_step_ctrl: RTL and testbench

- Command-driven sequencer for a Johnson (twisted-ring) phase register.
- Accepts "step N times in direction D" commands over a valid/ready handshake.
- Advances the internal Johnson register one code per clock, with pause and abort.
- Signals completion with a one-cycle done pulse. Sits between a host controller and phase-driven logic such as stepper drive or clock-phase select.

---
 rtl/johnson_step_ctrl.sv | 133 +++++++++++++
 tb/tb_johnson_step_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_step_ctrl.sv
// johnson_step_ctrl: command-driven sequencer for a Johnson (twisted-ring) phase register.
// Accepts "step N times in direction D" commands over valid/ready, advances the phase one
// code per clock, honours pause/abort, and pulses done for one cycle on completion.
// Optional feature macro: JOHNSON_WRAP_EN adds a registered 'wrap' pulse output.

module johnson_step_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] phase,
    output logic [CNT_W-1:0] steps_left,
    output logic             busy,
`ifdef JOHNSON_WRAP_EN
    output logic             wrap,
`endif
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] phase_fwd, phase_rev, phase_step;
`ifdef JOHNSON_WRAP_EN
    logic             wrap_q, wrap_d;
`endif

    // Next Johnson code in each direction; dir selects which one a step uses.
    always_comb begin
        phase_fwd  = {phase_q[WIDTH-2:0], ~phase_q[WIDTH-1]};
        phase_rev  = {~phase_q[0], phase_q[WIDTH-1:1]};
        phase_step = dir_q ? phase_rev : phase_fwd;
    end

    // Next-state logic: accept, step, pause/abort handling.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        steps_d = steps_q;
        dir_d   = dir_q;
`ifdef JOHNSON_WRAP_EN
        wrap_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    dir_d   = cmd_dir;
                    steps_d = cmd_steps;
                    state_d = (cmd_steps != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    steps_d = '0;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else if (steps_q == '0) begin
                    // Unreachable in normal operation; finish rather than underflow.
                    state_d = S_DONE;
                end else begin
                    phase_d = phase_step;
                    steps_d = steps_q - CNT_W'(1);
`ifdef JOHNSON_WRAP_EN
                    wrap_d  = (phase_step == '0);
`endif
                    if (steps_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    steps_d = '0;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                // S_DONE: single-cycle completion state.
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            steps_q <= '0;
            dir_q   <= 1'b0;
`ifdef JOHNSON_WRAP_EN
            wrap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            steps_q <= steps_d;
            dir_q   <= dir_d;
`ifdef JOHNSON_WRAP_EN
            wrap_q  <= wrap_d;
`endif
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        cmd_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        phase      = phase_q;
        steps_left = steps_q;
`ifdef JOHNSON_WRAP_EN
        wrap       = wrap_q;
`endif
    end

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// tb_johnson_step_ctrl: directed and randomized checks of johnson_step_ctrl against a
// position-based reference model (phase tracked as an index around the 2*W-code ring).

module tb_johnson_step_ctrl;

    localparam int W = 4;
    localparam int C = 8;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_dir;
    logic [C-1:0] cmd_steps;
    logic         pause;
    logic         abort;
    logic [W-1:0] phase;
    logic [C-1:0] steps_left;
    logic         busy;
    logic         done;
`ifdef JOHNSON_WRAP_EN
    logic         wrap;
`endif

    johnson_step_ctrl #(
        .WIDTH(W),
        .CNT_W(C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .pause     (pause),
        .abort     (abort),
        .phase     (phase),
        .steps_left(steps_left),
        .busy      (busy),
`ifdef JOHNSON_WRAP_EN
        .wrap      (wrap),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int done_seen;
    int wrap_seen;

    // Reference model: ring position, remaining count, mode, direction, wrap flag.
    int m_mode;
    int m_pos;
    int m_left;
    int m_dir;
    int m_wrap;

    // Johnson code at ring position k: k ones filling from the LSB, then zeros filling
    // from the LSB once all W bits are set.
    function automatic logic [W-1:0] code_of(input int k);
        int v;
        if (k <= W) v = (1 << k) - 1;
        else        v = ((1 << W) - 1) & ~((1 << (k - W)) - 1);
        return v[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pos  = 0;
        m_left = 0;
        m_dir  = 0;
        m_wrap = 0;
    endtask

    task automatic check_all();
        chk("phase",      {28'd0, phase},      {28'd0, code_of(m_pos)});
        chk("steps_left", {24'd0, steps_left}, m_left);
        chk("busy",       {31'd0, busy},       {31'd0, (m_mode != M_IDLE)});
        chk("done",       {31'd0, done},       {31'd0, (m_mode == M_DONE)});
        chk("cmd_ready",  {31'd0, cmd_ready},  {31'd0, (m_mode == M_IDLE)});
`ifdef JOHNSON_WRAP_EN
        chk("wrap",       {31'd0, wrap},       m_wrap);
`endif
    endtask

    // One clock: drive inputs, advance model at the edge, check 1 time unit later.
    task automatic tick(input logic cv, input logic cd, input logic [C-1:0] cs,
                        input logic pa, input logic ab);
        cmd_valid = cv;
        cmd_dir   = cd;
        cmd_steps = cs;
        pause     = pa;
        abort     = ab;
        @(posedge clk);
        m_wrap = 0;
        case (m_mode)
            M_IDLE: if (cv) begin
                m_dir  = int'(cd);
                m_left = int'(cs);
                m_mode = (cs != 0) ? M_RUN : M_DONE;
            end
            M_RUN: begin
                if (ab) begin
                    m_mode = M_IDLE;
                    m_left = 0;
                end else if (pa) begin
                    m_mode = M_PAUSE;
                end else begin
                    m_pos  = (m_dir != 0) ? (m_pos + 2*W - 1) % (2*W) : (m_pos + 1) % (2*W);
                    m_left = m_left - 1;
                    m_wrap = (m_pos == 0) ? 1 : 0;
                    if (m_left == 0) m_mode = M_DONE;
                end
            end
            M_PAUSE: begin
                if (ab) begin
                    m_mode = M_IDLE;
                    m_left = 0;
                end else if (!pa) begin
                    m_mode = M_RUN;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        #1;
        check_all();
        if (done === 1'b1) done_seen++;
`ifdef JOHNSON_WRAP_EN
        if (wrap === 1'b1) wrap_seen++;
`endif
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_steps = '0;
        pause     = 1'b0;
        abort     = 1'b0;
        model_reset();

        // Reset state, then release between edges.
        #12;
        chk("rst_phase", {28'd0, phase}, 32'd0);
        chk("rst_steps", {24'd0, steps_left}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Forward 8 from 0000: full loop back to 0000, single done pulse.
        done_seen = 0;
        wrap_seen = 0;
        tick(1'b1, 1'b0, 8'd8, 1'b0, 1'b0);
        repeat (8) idle_tick();
        chk("fwd8_phase", {28'd0, phase}, 32'd0);
        idle_tick();
        chk("fwd8_ready_after_done", {31'd0, cmd_ready}, 32'd1);
        chk("fwd8_done_count", done_seen, 32'd1);
`ifdef JOHNSON_WRAP_EN
        chk("fwd8_wrap_count", wrap_seen, 32'd1);
`endif

        // Reach 0011, then reverse 3.
        tick(1'b1, 1'b0, 8'd2, 1'b0, 1'b0);
        repeat (3) idle_tick();
        chk("pre_rev_phase", {28'd0, phase}, 32'h3);
        tick(1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
        repeat (4) idle_tick();
        chk("rev3_final", {28'd0, phase}, 32'h8);

        // Back to 0000, then forward 5 with a 3-cycle pause after step 2.
        tick(1'b1, 1'b0, 8'd1, 1'b0, 1'b0);
        repeat (2) idle_tick();
        done_seen = 0;
        tick(1'b1, 1'b0, 8'd5, 1'b0, 1'b0);
        repeat (2) idle_tick();
        repeat (3) tick(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("pause_phase", {28'd0, phase}, 32'h3);
        chk("pause_steps", {24'd0, steps_left}, 32'd3);
        repeat (6) idle_tick();
        chk("pause_done_count", done_seen, 32'd1);

        // Return to 0000, forward 6, abort+pause together after step 2.
        tick(1'b1, 1'b0, 8'd3, 1'b0, 1'b0);
        repeat (4) idle_tick();
        done_seen = 0;
        tick(1'b1, 1'b0, 8'd6, 1'b0, 1'b0);
        repeat (2) idle_tick();
        tick(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("abort_phase", {28'd0, phase}, 32'h3);
        chk("abort_steps", {24'd0, steps_left}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) idle_tick();
        chk("abort_no_done", done_seen, 32'd0);

        // Zero-step command with cmd_valid held through DONE.
        tick(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        chk("zero_done", {31'd0, done}, 32'd1);
        tick(1'b1, 1'b0, 8'd4, 1'b0, 1'b0);
        chk("zero_no_accept_in_done", {24'd0, steps_left}, 32'd0);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0);
        repeat (6) idle_tick();

        // Async reset mid-run at 0111 (phase is 0011 here).
        tick(1'b1, 1'b0, 8'd20, 1'b0, 1'b0);
        idle_tick();
        chk("pre_reset_phase", {28'd0, phase}, 32'h7);
        #2;
        rst = 1'b0;
        #1;
        chk("async_phase", {28'd0, phase}, 32'd0);
        chk("async_busy",  {31'd0, busy}, 32'd0);
        chk("async_done",  {31'd0, done}, 32'd0);
        chk("async_steps", {24'd0, steps_left}, 32'd0);
        model_reset();
        #2;
        rst = 1'b1;

        // Long forward run crossing the zero code twice.
        tick(1'b1, 1'b0, 8'd17, 1'b0, 1'b0);
        repeat (19) idle_tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 C'($urandom_range(0, 9)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
